// File: rtl/cpu_mem_if.sv
// Shared single-port memory bus between the CPU control sequencer (master)
// and the memory subsystem (slave).
interface cpu_mem_if;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       mem_ready;
    logic [7:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit softcore: fetch/decode/exec/mem/wb,
// memory-port arbitration between fetch and LB/SB, and bus timeout detection.
module cpu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                branch_cond,
    cpu_mem_if.master           mem,
    output logic [7:0]          ir,
    output logic [7:0]          mdr,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                reg_we,
    output logic                insn_valid,
    output logic                bus_err,
    output logic [RETIRE_W-1:0] insn_retired,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_CPYPC  = 4'h8;
    localparam logic [3:0] OP_LB     = 4'h9;
    localparam logic [3:0] OP_SB     = 4'hA;
    localparam logic [3:0] OP_JMPADR = 4'hB;
    localparam logic [3:0] OP_JMPI   = 4'hC;
    localparam logic [3:0] OP_BLT    = 4'hD;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            ir_q, ir_d;
    logic [7:0]            mdr_q, mdr_d;
    logic [7:0]            wait_q, wait_d;
    logic                  bus_err_q, bus_err_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    logic                  mem_req_c;
    logic                  mem_we_c;
    logic                  mem_addr_sel_c;
    logic                  pc_inc_c;
    logic                  pc_load_c;
    logic                  reg_we_c;
    logic                  insn_valid_c;
    logic                  retire_c;

    logic [3:0]            opcode;
    logic                  is_lb;
    logic                  is_sb;

    assign opcode = ir_q[7:4];
    assign is_lb  = (opcode == OP_LB);
    assign is_sb  = (opcode == OP_SB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= 8'h00;
            mdr_q     <= 8'h00;
            wait_q    <= 8'h00;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        mdr_d          = mdr_q;
        wait_d         = wait_q;
        bus_err_d      = bus_err_q;
        retired_d      = retired_q;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        pc_inc_c       = 1'b0;
        pc_load_c      = 1'b0;
        reg_we_c       = 1'b0;
        insn_valid_c   = 1'b0;
        retire_c       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d   = S_FETCH;
                    bus_err_d = 1'b0;
                    wait_d    = 8'h00;
                end
            end

            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_d     = mem.mem_rdata;
                    pc_inc_c = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_DECODE: begin
                insn_valid_c = 1'b1;
                if (is_lb || is_sb) begin
                    state_d = S_MEM;
                    wait_d  = 8'h00;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                insn_valid_c = 1'b1;
                retire_c     = 1'b1;
                if (opcode <= OP_CPYPC) begin
                    reg_we_c = 1'b1;
                end else if (opcode == OP_JMPADR || opcode == OP_JMPI) begin
                    pc_load_c = 1'b1;
                end else if (opcode >= OP_BLT) begin
                    pc_load_c = branch_cond;
                end
            end

            S_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = is_sb;
                if (mem.mem_ready) begin
                    if (is_sb) begin
                        retire_c = 1'b1;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WB: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // run is only looked at here, so an instruction in flight always completes
        if (retire_c) begin
            retired_d = retired_q + RETIRE_W'(1);
            wait_d    = 8'h00;
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    assign mem.mem_req      = mem_req_c;
    assign mem.mem_we       = mem_we_c;
    assign mem.mem_addr_sel = mem_addr_sel_c;

    assign ir           = ir_q;
    assign mdr          = mdr_q;
    assign pc_inc       = pc_inc_c;
    assign pc_load      = pc_load_c;
    assign reg_we       = reg_we_c;
    assign insn_valid   = insn_valid_c;
    assign bus_err      = bus_err_q;
    assign insn_retired = retired_q;
    assign state        = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: scoreboarded instruction sequences,
// timeout, run handling, async reset and retire-counter wrap.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        branch_cond;
    logic [7:0]  ir, mdr;
    logic        pc_inc, pc_load, reg_we, insn_valid, bus_err;
    logic [15:0] insn_retired;
    logic [2:0]  state;

    logic        run_w;
    logic [7:0]  ir_w, mdr_w;
    logic        pc_inc_w, pc_load_w, reg_we_w, insn_valid_w, bus_err_w;
    logic [3:0]  retired_w;
    logic [2:0]  state_w;

    cpu_mem_if mbus ();
    cpu_mem_if mbus_w ();

    cpu_ctrl_fsm #(.MEM_TIMEOUT(15), .RETIRE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .branch_cond(branch_cond),
        .mem(mbus), .ir(ir), .mdr(mdr), .pc_inc(pc_inc), .pc_load(pc_load),
        .reg_we(reg_we), .insn_valid(insn_valid), .bus_err(bus_err),
        .insn_retired(insn_retired), .state(state)
    );

    // Narrow counter instance so the wrap can be reached in a few dozen cycles
    cpu_ctrl_fsm #(.MEM_TIMEOUT(15), .RETIRE_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run_w), .branch_cond(1'b0),
        .mem(mbus_w), .ir(ir_w), .mdr(mdr_w), .pc_inc(pc_inc_w), .pc_load(pc_load_w),
        .reg_we(reg_we_w), .insn_valid(insn_valid_w), .bus_err(bus_err_w),
        .insn_retired(retired_w), .state(state_w)
    );

    typedef struct packed {
        logic [7:0]  ir;
        logic [7:0]  mdr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_cnt;
    logic [7:0]  m_mdr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] strobes();
        return {mbus.mem_req, mbus.mem_we, mbus.mem_addr_sel, pc_inc, pc_load,
                reg_we, insn_valid, state};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; branch_cond = 1'b0;
        mbus.mem_ready = 1'b0; mbus.mem_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b1;
        m_cnt = 16'h0; m_mdr = 8'h00;
        sb_q.delete();
    endtask

    // Drives one instruction from its FETCH cycle to retire with zero-wait fetch.
    task automatic do_insn(input logic [7:0] insn, input int mwait, input logic [7:0] rdata,
                           input logic bc, input logic drop_run, output int ncyc);
        logic [3:0] opc;
        logic       lb, sb, pcl;
        logic [9:0] ev;
        exp_t       e;
        opc = insn[7:4];
        lb  = (opc == 4'h9);
        sb  = (opc == 4'hA);
        pcl = (opc == 4'hB || opc == 4'hC) ? 1'b1 : (opc >= 4'hD) ? bc : 1'b0;
        m_cnt = m_cnt + 16'd1;
        if (lb) m_mdr = rdata;
        e.ir = insn; e.mdr = m_mdr; e.cnt = m_cnt;
        sb_q.push_back(e);

        @(negedge clk);
        mbus.mem_ready = 1'b1; mbus.mem_rdata = insn; #1;
        ncyc = 1;
        ev = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        n_checks++;
        if (strobes() !== ev) begin
            n_fail++; $display("FAIL fetch_%h: strobes got %b want %b", insn, strobes(), ev);
        end

        @(negedge clk);
        mbus.mem_ready = 1'b0; mbus.mem_rdata = 8'h00;
        if (drop_run) run = 1'b0;
        #1; ncyc++;
        ev = {7'b0000001, 3'd2};
        n_checks++;
        if (strobes() !== ev || ir !== insn) begin
            n_fail++; $display("FAIL decode_%h: strobes %b ir %h want %b ir %h", insn, strobes(), ir, ev, insn);
        end

        if (lb || sb) begin
            for (int k = 0; k <= mwait; k++) begin
                @(negedge clk);
                mbus.mem_ready = (k == mwait); mbus.mem_rdata = rdata; #1; ncyc++;
                ev = {1'b1, sb, 1'b1, 4'b0000, 3'd4};
                n_checks++;
                if (strobes() !== ev) begin
                    n_fail++; $display("FAIL mem_%h: strobes got %b want %b", insn, strobes(), ev);
                end
            end
            if (lb) begin
                @(negedge clk);
                mbus.mem_ready = 1'b0; #1; ncyc++;
                ev = {5'b00000, 1'b1, 1'b0, 3'd5};
                n_checks++;
                if (strobes() !== ev) begin
                    n_fail++; $display("FAIL wb_%h: strobes got %b want %b", insn, strobes(), ev);
                end
            end
        end else begin
            @(negedge clk);
            branch_cond = bc; #1; ncyc++;
            ev = {4'b0000, pcl, (opc <= 4'h8), 1'b1, 3'd3};
            n_checks++;
            if (strobes() !== ev) begin
                n_fail++; $display("FAIL exec_%h: strobes got %b want %b", insn, strobes(), ev);
            end
        end

        e = sb_q.pop_front();
        n_checks++;
        if (ir !== e.ir || mdr !== e.mdr) begin
            n_fail++; $display("FAIL retire_data_%h: ir %h mdr %h want ir %h mdr %h", insn, ir, mdr, e.ir, e.mdr);
        end
        @(posedge clk); #1;
        n_checks++;
        if (insn_retired !== e.cnt || state !== (run ? 3'd1 : 3'd0)) begin
            n_fail++; $display("FAIL retire_%h: count %h state %0d want count %h state %0d",
                               insn, insn_retired, state, e.cnt, run ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++;
        if (strobes() !== 10'b0 || ir !== 8'h00 || mdr !== 8'h00 || bus_err !== 1'b0 || insn_retired !== 16'h0) begin
            n_fail++; $display("FAIL reset_state: strobes %b ir %h mdr %h err %b cnt %h want all zero",
                               strobes(), ir, mdr, bus_err, insn_retired);
        end
    endtask

    task automatic test_alu();
        int nc;
        apply_reset();
        #1;
        n_checks++;
        if (strobes() !== 10'b0) begin
            n_fail++; $display("FAIL idle_strobes: got %b want 0", strobes());
        end
        do_insn(8'h05, 0, 8'h00, 1'b0, 1'b0, nc);
        n_checks++;
        if (nc !== 3) begin n_fail++; $display("FAIL alu_latency: got %0d want 3", nc); end
        do_insn(8'h85, 0, 8'h00, 1'b0, 1'b0, nc);
    endtask

    task automatic test_lb();
        int nc;
        apply_reset();
        do_insn(8'h93, 2, 8'hA7, 1'b0, 1'b0, nc);
        n_checks++;
        if (nc !== 6 || mdr !== 8'hA7) begin
            n_fail++; $display("FAIL lb_latency: cycles %0d mdr %h want 6 a7", nc, mdr);
        end
    endtask

    task automatic test_back_to_back();
        int nc;
        apply_reset();
        do_insn(8'hA1, 0, 8'h00, 1'b0, 1'b0, nc);
        n_checks++;
        if (nc !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", nc); end
        do_insn(8'hF0, 0, 8'h00, 1'b1, 1'b0, nc);
        do_insn(8'hF8, 0, 8'h00, 1'b0, 1'b0, nc);
        n_checks++;
        if (insn_retired !== 16'd3) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 3", insn_retired);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 14) run = 1'b0;
            #1;
            n_checks++;
            if (strobes() !== {1'b1, 6'b000000, 3'd1} || bus_err !== 1'b0) begin
                n_fail++; $display("FAIL timeout_wait_%0d: strobes %b err %b", i, strobes(), bus_err);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (strobes() !== 10'b0 || bus_err !== 1'b1 || insn_retired !== 16'h0) begin
                n_fail++; $display("FAIL timeout_flag_%0d: strobes %b err %b cnt %h want 0 1 0",
                                   i, strobes(), bus_err, insn_retired);
            end
        end
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 3'd1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: state %0d err %b want 1 0", state, bus_err);
        end
    endtask

    task automatic test_ready_on_timeout();
        apply_reset();
        for (int i = 0; i < 14; i++) @(negedge clk);
        @(negedge clk);
        mbus.mem_ready = 1'b1; mbus.mem_rdata = 8'h05; #1;
        n_checks++;
        if (pc_inc !== 1'b1) begin n_fail++; $display("FAIL ready_wins_pcinc: got %b want 1", pc_inc); end
        @(posedge clk); #1;
        n_checks++;
        if (state !== 3'd2 || bus_err !== 1'b0 || ir !== 8'h05) begin
            n_fail++; $display("FAIL ready_wins: state %0d err %b ir %h want 2 0 05", state, bus_err, ir);
        end
    endtask

    task automatic test_run_drop();
        int nc;
        apply_reset();
        do_insn(8'hC4, 0, 8'h00, 1'b0, 1'b1, nc);
        @(negedge clk); #1;
        n_checks++;
        if (state !== 3'd0 || insn_retired !== 16'd1) begin
            n_fail++; $display("FAIL run_drop_idle: state %0d cnt %h want 0 1", state, insn_retired);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int nc;
        apply_reset();
        do_insn(8'h05, 0, 8'h00, 1'b0, 1'b0, nc);
        @(negedge clk);
        mbus.mem_ready = 1'b0; #1;
        n_checks++;
        if (mbus.mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_fetch_req: got %b want 1", mbus.mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mbus.mem_req !== 1'b0 || state !== 3'd0 || ir !== 8'h00 || insn_retired !== 16'h0) begin
            n_fail++; $display("FAIL async_reset: req %b state %0d ir %h cnt %h want 0 0 00 0000",
                               mbus.mem_req, state, ir, insn_retired);
        end
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
    endtask

    task automatic test_wrap();
        bit hit;
        @(negedge clk); run_w = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (retired_w == 4'hF) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL wrap_reach: count %h never reached f", retired_w); end
        hit = 1'b0;
        for (int i = 0; i < 6 && !hit; i++) begin
            @(negedge clk);
            if (retired_w != 4'hF) hit = 1'b1;
        end
        n_checks++;
        if (!hit || retired_w !== 4'h0 || bus_err_w !== 1'b0) begin
            n_fail++; $display("FAIL wrap: count %h err %b want 0 0", retired_w, bus_err_w);
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; branch_cond = 1'b0; run_w = 1'b0;
        mbus.mem_ready = 1'b0; mbus.mem_rdata = 8'h00;
        mbus_w.mem_ready = 1'b1; mbus_w.mem_rdata = 8'h05;
        m_cnt = 16'h0; m_mdr = 8'h00;
        test_reset();
        test_alu();
        test_lb();
        test_back_to_back();
        test_timeout();
        test_ready_on_timeout();
        test_run_drop();
        test_reset_mid_fetch();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
